imem_loader: RTL and testbench
==============================

# imem_loader

Hardware program loader for the SoC. Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words and writes them into instruction memory through its write port, starting at word address 0. The processor is held in reset throughout the load. Loading ends at the first all-zero word, which is the program-end marker the core halts on; that word is also written, and the processor is then released.

## Interface

Parameters:
- ADDR_WIDTH, default 8: imem word-address width. DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE and ERR.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  program byte.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  imem write enable.
- imem_addr  output  ADDR_WIDTH  imem word address.
- imem_wdata  output  32  imem write data.
- core_rst  output  1  active-high reset to the processor.
- busy  output  1  high in RECV and WRITE.
- done  output  1  load completed with terminator.
- error  output  1  imem overflowed before a terminator arrived.
- word_count  output  ADDR_WIDTH+1  words written in the current load, terminator included.

## Operation

- States: IDLE, RECV, WRITE, DONE, ERR.
- Reset values (rst low, applied immediately): state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, error=0, word_count=0, byte index=0.
- IDLE: core_rst=1. When start=1, go to RECV; clear imem_addr, word_count and byte index.
- RECV: in_ready=1.
  - A byte is accepted when in_valid && in_ready.
  - Byte k (k=0..3) goes to word bits [8k+7:8k], so the first byte is the LSB.
  - On acceptance of byte 3, go to WRITE.
  - Cycles with in_valid low do not advance the byte index.
- WRITE: exactly one cycle, with in_ready=0, imem_we=1, imem_addr=current address and imem_wdata=assembled word. The write commits on the edge that leaves WRITE; word_count increments on that same edge. Next state:
  - assembled word == 32'h0: DONE.
  - else, imem_addr == DEPTH-1: ERR. imem_addr holds its value; it does not wrap.
  - else: imem_addr increments and the state returns to RECV with byte index 0.
- DONE: done=1, core_rst=0, in_ready=0. Holds until start.
- ERR: error=1, core_rst=1, in_ready=0. Holds until start.
- start in DONE or ERR: the same as from IDLE, except that done and error clear and core_rst returns to 1 on the transition edge.
- start in RECV or WRITE is ignored.
- in_valid outside RECV is ignored; no byte is consumed.
- Async reset mid-load: all state returns to reset values. imem contents already written are not cleared. A partially assembled word is discarded.

## Timing

- All outputs are registered; no output depends combinationally on an input.
- The first byte can be accepted in the cycle after the edge on which start is sampled.
- Byte 3 accepted at edge E: imem_we=1 during cycle E..E+1; the write commits at E+1.
- Throughput: at most one word per 5 cycles (4 RECV + 1 WRITE).
- Terminator written at edge T: done=1 and core_rst=0 from T. Processor reset release lags the final write by zero extra cycles.
- Overflow write at edge T: error=1 from T; core_rst stays 1.

## Test plan

- Reset: hold rst=0 for 3 cycles with in_valid=1 and start=1. Required: core_rst=1, in_ready=0, imem_we=0, done=0, error=0, word_count=0 throughout.
- Normal load (ADDR_WIDTH=8): start, then bytes 93 00 50 00, 13 01 A0 00, 00 00 00 00 with in_valid held high. Required:
  - Writes [0]=00500093, [1]=00A00113, [2]=00000000, each with imem_we high for exactly one cycle.
  - word_count=3, done=1, core_rst=0 from the edge of the third write.
- Backpressure: same stream with in_valid randomly gapped, and in_valid held high during every WRITE cycle. Required: identical imem contents, no byte lost or duplicated, in_ready=0 in every WRITE cycle.
- Overflow (ADDR_WIDTH=2): four nonzero words 11111111 to 44444444. Required:
  - Writes to addresses 0..3.
  - error=1 after the 4th write; imem_addr stays 3.
  - core_rst stays 1 and in_ready=0 afterwards, even with in_valid held high.
- Restart from DONE: after the normal load, start with the stream 37 05 00 00, 00 00 00 00. Required:
  - core_rst=1 and done=0 on the start edge.
  - [0]=00000537, [1]=00000000.
  - word_count=2, done=1.
- Async reset mid-word: after 2 bytes of a word, pulse rst low asynchronously between clock edges. Required:
  - Reset values appear immediately, before the next edge.
  - A subsequent start followed by 78 56 34 12, 00 00 00 00 writes [0]=12345678, with no stale bytes.

Source files
------------

// File: rtl/imem_loader.sv
// Program loader: assembles little-endian bytes into 32-bit words and writes them to imem.
// The processor stays in reset until the all-zero terminator word has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_idx;
  logic [23:0] byte_buf;
  logic        accept;
  logic        begin_load;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    begin_load = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          begin_load = 1'b1;
          state_next = RECV;
        end
      end
      RECV: begin
        accept = in_valid && in_ready;
        if (accept && (byte_idx == 2'd3)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (imem_wdata == 32'h0) begin
          state_next = DONE;
        end else if (imem_addr == LAST_ADDR) begin
          state_next = ERR;
        end else begin
          state_next = RECV;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      byte_idx   <= '0;
      byte_buf   <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == RECV);
      imem_we  <= (state_next == WRITE);
      busy     <= (state_next == RECV) || (state_next == WRITE);
      done     <= (state_next == DONE);
      error    <= (state_next == ERR);
      core_rst <= (state_next != DONE);

      if (begin_load) begin
        imem_addr  <= '0;
        word_count <= '0;
        byte_idx   <= '0;
        byte_buf   <= '0;
      end

      // The fourth byte completes the word directly into the write-data register.
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: byte_buf[7:0]   <= in_data;
          2'd1: byte_buf[15:8]  <= in_data;
          2'd2: byte_buf[23:16] <= in_data;
          default: imem_wdata   <= {in_data, byte_buf};
        endcase
      end

      if (state == WRITE) begin
        word_count <= word_count + COUNT_ONE;
        if (state_next == RECV) begin
          imem_addr <= imem_addr + ADDR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; a deep and a 4-word instance share one input stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready8, we8, core_rst8, busy8, done8, error8;
  logic [7:0]  addr8;
  logic [31:0] wdata8;
  logic [8:0]  wc8;

  logic        in_ready2, we2, core_rst2, busy2, done2, error2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  wc2;

  logic [31:0] mem8 [256];
  logic [31:0] mem2 [4];
  int          wr8 = 0;
  int          wr2 = 0;
  int          checks = 0;
  int          errors = 0;

  imem_loader #(.ADDR_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready8), .imem_we(we8), .imem_addr(addr8), .imem_wdata(wdata8),
    .core_rst(core_rst8), .busy(busy8), .done(done8), .error(error8), .word_count(wc8)
  );

  imem_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .core_rst(core_rst2), .busy(busy2), .done(done2), .error(error2), .word_count(wc2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Memory models fill from the write port mid-cycle; each cycle of imem_we counts as one write.
  always @(negedge clk) begin
    if (we8) begin
      mem8[addr8] = wdata8;
      wr8++;
      checkOutput("ready8_in_write", in_ready8, 0);
    end
    if (we2) begin
      mem2[addr2] = wdata2;
      wr2++;
      checkOutput("ready2_in_write", in_ready2, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready8 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) checkOutput("ready_timeout", 0, 1);
    else tick();
  endtask

  // Byte 0 of every word is never gapped so in_valid stays high through each WRITE cycle.
  task automatic applyStimulus(input logic [31:0] w, input bit gapped);
    for (int k = 0; k < 4; k++) begin
      pushByte(w[8*k +: 8], (gapped && k != 0) ? int'($urandom_range(1, 2)) : 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) begin
      tick();
      checkOutput("rst_core_rst", core_rst8, 1);
      checkOutput("rst_in_ready", in_ready8, 0);
      checkOutput("rst_imem_we", we8, 0);
      checkOutput("rst_done", done8, 0);
      checkOutput("rst_error", error8, 0);
      checkOutput("rst_word_count", wc8, 0);
    end
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick();

    // Normal load
    startLoad();
    checkOutput("norm_busy", busy8, 1);
    checkOutput("norm_ready", in_ready8, 1);
    applyStimulus(32'h00500093, 0);
    applyStimulus(32'h00A00113, 0);
    applyStimulus(32'h00000000, 0);
    checkOutput("norm_done_before_T", done8, 0);
    tick();
    in_valid = 1'b0;
    checkOutput("norm_done", done8, 1);
    checkOutput("norm_core_rst", core_rst8, 0);
    checkOutput("norm_word_count", wc8, 3);
    checkOutput("norm_writes", wr8, 3);
    checkOutput("norm_mem0", mem8[0], 32'h00500093);
    checkOutput("norm_mem1", mem8[1], 32'h00A00113);
    checkOutput("norm_mem2", mem8[2], 32'h00000000);

    // Backpressure
    for (int i = 0; i < 3; i++) mem8[i] = 32'hDEADBEEF;
    wr8 = 0;
    startLoad();
    applyStimulus(32'h00500093, 1);
    applyStimulus(32'h00A00113, 1);
    applyStimulus(32'h00000000, 1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_done", done8, 1);
    checkOutput("bp_word_count", wc8, 3);
    checkOutput("bp_writes", wr8, 3);
    checkOutput("bp_mem0", mem8[0], 32'h00500093);
    checkOutput("bp_mem1", mem8[1], 32'h00A00113);
    checkOutput("bp_mem2", mem8[2], 32'h00000000);

    // Restart from DONE
    wr8 = 0;
    startLoad();
    checkOutput("rs_core_rst", core_rst8, 1);
    checkOutput("rs_done", done8, 0);
    checkOutput("rs_word_count_clr", wc8, 0);
    applyStimulus(32'h00000537, 0);
    applyStimulus(32'h00000000, 0);
    tick();
    in_valid = 1'b0;
    checkOutput("rs_mem0", mem8[0], 32'h00000537);
    checkOutput("rs_mem1", mem8[1], 32'h00000000);
    checkOutput("rs_word_count", wc8, 2);
    checkOutput("rs_done_end", done8, 1);
    checkOutput("rs_writes", wr8, 2);

    // Async reset in the middle of the second word
    startLoad();
    applyStimulus(32'h11223344, 0);
    pushByte(8'hAA, 0);
    pushByte(8'hBB, 0);
    checkOutput("ar_wc_before", wc8, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("ar_in_ready", in_ready8, 0);
    checkOutput("ar_busy", busy8, 0);
    checkOutput("ar_core_rst", core_rst8, 1);
    checkOutput("ar_word_count", wc8, 0);
    checkOutput("ar_addr", addr8, 0);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    wr8 = 0;
    startLoad();
    applyStimulus(32'h12345678, 0);
    applyStimulus(32'h00000000, 0);
    tick();
    in_valid = 1'b0;
    checkOutput("ar_mem0", mem8[0], 32'h12345678);
    checkOutput("ar_mem1", mem8[1], 32'h00000000);
    checkOutput("ar_reload_wc", wc8, 2);
    checkOutput("ar_reload_done", done8, 1);

    // Overflow on the 4-word instance
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    wr2 = 0;
    startLoad();
    applyStimulus(32'h11111111, 0);
    applyStimulus(32'h22222222, 0);
    applyStimulus(32'h33333333, 0);
    applyStimulus(32'h44444444, 0);
    checkOutput("ov_error_before_T", error2, 0);
    tick();
    checkOutput("ov_error", error2, 1);
    checkOutput("ov_done", done2, 0);
    checkOutput("ov_addr", addr2, 3);
    checkOutput("ov_core_rst", core_rst2, 1);
    checkOutput("ov_in_ready", in_ready2, 0);
    checkOutput("ov_word_count", wc2, 4);
    checkOutput("ov_mem0", mem2[0], 32'h11111111);
    checkOutput("ov_mem1", mem2[1], 32'h22222222);
    checkOutput("ov_mem2", mem2[2], 32'h33333333);
    checkOutput("ov_mem3", mem2[3], 32'h44444444);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick();
    checkOutput("ov_hold_ready", in_ready2, 0);
    checkOutput("ov_hold_core_rst", core_rst2, 1);
    checkOutput("ov_hold_addr", addr2, 3);
    checkOutput("ov_hold_writes", wr2, 4);
    checkOutput("ov_hold_error", error2, 1);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
